// File: rtl/vram_arbiter.sv
// VRAM time-slot arbiter: an 8-slot cell shared by display fetches and CPU accesses.
// Define VRAM_ARBITER_EXTRA_SLOTS_EN to let slots 5 and 6 also serve CPU requests.
module vram_arbiter #(
   parameter int ADDR_WIDTH = 15
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  slot_en,
   input  logic                  line_start,
   input  logic [ADDR_WIDTH-1:0] disp_name_addr,
   input  logic [ADDR_WIDTH-1:0] disp_colour_addr,
   input  logic [ADDR_WIDTH-1:0] disp_pattern_addr,
   output logic [7:0]            disp_name,
   output logic [7:0]            disp_colour,
   output logic [7:0]            disp_pattern,
   output logic                  disp_valid,
   input  logic                  cpu_rd_req,
   input  logic [ADDR_WIDTH-1:0] cpu_rd_addr,
   output logic                  cpu_rd_ack,
   output logic [7:0]            cpu_rd_data,
   input  logic                  cpu_wr_req,
   input  logic [ADDR_WIDTH-1:0] cpu_wr_addr,
   input  logic [7:0]            cpu_wr_data,
   output logic                  cpu_wr_ack,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   output logic [7:0]            ram_wdata,
   input  logic [7:0]            ram_rdata
);

   typedef enum logic [2:0] {
      OWN_NONE,
      OWN_NAME,
      OWN_COLOUR,
      OWN_PATTERN,
      OWN_CPU_RD,
      OWN_CPU_WR
   } owner_t;

   logic [2:0] slot;
   logic [2:0] slot_next;
   owner_t     owner_p0;
   owner_t     owner_next;
   logic       rd_served;
   logic       wr_served;
   logic       rd_pending;
   logic       wr_pending;

   always_comb begin
      slot_next  = line_start ? 3'd0 : slot + 3'd1;
      rd_pending = cpu_rd_req && !rd_served;
      wr_pending = cpu_wr_req && !wr_served;
      owner_next = OWN_NONE;
      case (slot_next)
         3'd0: owner_next = OWN_NAME;
         3'd1: owner_next = OWN_COLOUR;
         3'd2: owner_next = OWN_PATTERN;
         3'd3: owner_next = rd_pending ? OWN_CPU_RD : OWN_NONE;
         3'd4: owner_next = wr_pending ? OWN_CPU_WR : OWN_NONE;
`ifdef VRAM_ARBITER_EXTRA_SLOTS_EN
         3'd5: owner_next = rd_pending ? OWN_CPU_RD : (wr_pending ? OWN_CPU_WR : OWN_NONE);
         3'd6: owner_next = wr_pending ? OWN_CPU_WR : (rd_pending ? OWN_CPU_RD : OWN_NONE);
`endif
         default: owner_next = OWN_NONE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot         <= 3'd0;
         owner_p0     <= OWN_NONE;
         rd_served    <= 1'b0;
         wr_served    <= 1'b0;
         ram_addr     <= '0;
         ram_we       <= 1'b0;
         ram_wdata    <= 8'h00;
         disp_name    <= 8'h00;
         disp_colour  <= 8'h00;
         disp_pattern <= 8'h00;
         disp_valid   <= 1'b0;
         cpu_rd_data  <= 8'h00;
         cpu_rd_ack   <= 1'b0;
         cpu_wr_ack   <= 1'b0;
      end else begin
         disp_valid <= 1'b0;
         cpu_rd_ack <= 1'b0;
         cpu_wr_ack <= 1'b0;
         if (!cpu_rd_req) rd_served <= 1'b0;
         if (!cpu_wr_req) wr_served <= 1'b0;
         if (slot_en) begin
            slot <= slot_next;
            // Leaving a slot: retire whatever the owner tag says was issued,
            // independent of where a resync moves the slot counter.
            case (owner_p0)
               OWN_NAME:    disp_name <= ram_rdata;
               OWN_COLOUR:  disp_colour <= ram_rdata;
               OWN_PATTERN: begin
                  disp_pattern <= ram_rdata;
                  disp_valid   <= 1'b1;
               end
               OWN_CPU_RD: begin
                  cpu_rd_data <= ram_rdata;
                  cpu_rd_ack  <= 1'b1;
               end
               OWN_CPU_WR: cpu_wr_ack <= 1'b1;
               default: ;
            endcase
            // Entering a slot: issue its access; idle slots keep the old address.
            owner_p0 <= owner_next;
            ram_we   <= 1'b0;
            case (owner_next)
               OWN_NAME:    ram_addr <= disp_name_addr;
               OWN_COLOUR:  ram_addr <= disp_colour_addr;
               OWN_PATTERN: ram_addr <= disp_pattern_addr;
               OWN_CPU_RD: begin
                  ram_addr  <= cpu_rd_addr;
                  rd_served <= 1'b1;
               end
               OWN_CPU_WR: begin
                  ram_addr  <= cpu_wr_addr;
                  ram_wdata <= cpu_wr_data;
                  ram_we    <= 1'b1;
                  wr_served <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
